// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;

    // Scan FSM: parked, dark guard interval, digit lit
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Panel polarity selectors for DISPLAY_TYPE
    localparam string DISP_ANODE_COMMON   = "ANODE_COMMON";
    localparam string DISP_CATHODE_COMMON = "CATHODE_COMMON";

    // Active-high segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_to_7seg.sv
// Nibble to active-high 7-segment pattern; non-BCD codes show a dash.
module bcd_to_7seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure lookup, polarity is applied by the caller
    always_comb begin
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Each slot is SCAN_DIV cycles:
// BLANK_CYCLES dark (ghosting guard) followed by the selected digit lit.
// Slot order is round-robin over the enabled digits.
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int    NUM_DIGITS   = 8,
    parameter int    SCAN_DIV     = 100000,
    parameter int    BLANK_CYCLES = 1000,
    parameter string DISPLAY_TYPE = DISP_ANODE_COMMON
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic [7:0]              an,
    output logic [2:0]              scan_idx,
    output logic                    frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    // Common-anode panels sink current, so everything is active-low there
    localparam logic POL_LOW = (DISPLAY_TYPE == DISP_ANODE_COMMON);
    localparam logic [6:0] SEG_OFF = {7{POL_LOW}};
    localparam logic [7:0] AN_OFF  = {8{POL_LOW}};

    scan_state_t      r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_scan_idx;
    logic [3:0]       r_nibble;
    logic             r_blank;
    logic [6:0]       r_seg;
    logic [7:0]       r_an;

    int               w_start;
    logic [2:0]       w_next_idx;
    logic [3:0]       w_cand_nib;
    logic             w_hi_zero;
    logic             w_cand_blank;
    logic [6:0]       w_pat;
    logic [6:0]       w_seg_on;
    logic [7:0]       w_an_on;

    // First enabled index at or after 'start', wrapping around the digit set
    function automatic logic [2:0] pick_from(input logic [NUM_DIGITS-1:0] en,
                                             input int start);
        logic [2:0] res;
        logic       found;
        res   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            int idx;
            idx = (start + k) % NUM_DIGITS;
            if (!found && en[IW'(idx)]) begin
                res   = 3'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Candidate for the next slot: its index, nibble and leading-zero decision
    always_comb begin
        w_start    = (r_state == IDLE) ? 0 : ((int'(r_scan_idx) + 1) % NUM_DIGITS);
        w_next_idx = pick_from(digit_en, w_start);
        w_cand_nib = 4'd0;
        w_hi_zero  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) == w_next_idx)
                w_cand_nib = digits[i*4 +: 4];
            // The digit itself plus every enabled digit above it must be zero
            if ((3'(i) == w_next_idx) || (3'(i) > w_next_idx && digit_en[i])) begin
                if (digits[i*4 +: 4] != 4'd0)
                    w_hi_zero = 1'b0;
            end
        end
        w_cand_blank = lz_blank && (w_next_idx != 3'd0) && w_hi_zero;
    end

    bcd_to_7seg u_dec (
        .i_nibble (r_nibble),
        .o_seg    (w_pat)
    );

    // Lit-phase output values, already in panel polarity
    always_comb begin
        w_seg_on = (r_blank ? 7'd0 : w_pat) ^ SEG_OFF;
        w_an_on  = (8'h01 << r_scan_idx) ^ AN_OFF;
    end

    // Scan FSM with registered panel outputs; reset darkens the panel at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_scan_idx <= 3'd0;
            r_nibble   <= 4'd0;
            r_blank    <= 1'b0;
            r_seg      <= SEG_OFF;
            r_an       <= AN_OFF;
        end else begin
            case (r_state)
                IDLE: begin
                    r_seg <= SEG_OFF;
                    r_an  <= AN_OFF;
                    if (|digit_en) begin
                        r_state    <= BLANK;
                        r_cnt      <= '0;
                        r_scan_idx <= w_next_idx;
                        r_nibble   <= w_cand_nib;
                        r_blank    <= w_cand_blank;
                    end
                end
                BLANK: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= DRIVE;
                        r_seg   <= w_seg_on;
                        r_an    <= w_an_on;
                    end
                end
                DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        // Slot boundary: the only place digit_en is honoured
                        r_cnt <= '0;
                        r_seg <= SEG_OFF;
                        r_an  <= AN_OFF;
                        if (|digit_en) begin
                            r_state    <= BLANK;
                            r_scan_idx <= w_next_idx;
                            r_nibble   <= w_cand_nib;
                            r_blank    <= w_cand_blank;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_seg   <= SEG_OFF;
                    r_an    <= AN_OFF;
                end
            endcase
        end
    end

    // Frame ends on the last cycle of a slot whose successor wraps (or repeats);
    // the successor is only known from digit_en on that cycle, hence not registered
    assign frame_tick = (r_state == DRIVE) && (r_cnt == SLOT_LAST) &&
                        (|digit_en) && (w_next_idx <= r_scan_idx);

    assign seg      = r_seg;
    assign an       = r_an;
    assign scan_idx = r_scan_idx;

endmodule
